// File: rtl/multi_cycle_controller_pkg.sv
// Shared encodings for the multi-cycle controller: states, opcodes, ALU codes, mux selects.
// Latency: n/a (types, constants and one pure helper function only).
// Backpressure: n/a.
package multi_cycle_controller_pkg;

    localparam int STATE_W = 4;
    localparam int ALUC_W  = 3;

    // Eleven live states; encodings 11..15 are unused and recover to FETCH.
    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    // Opcodes of the supported instruction classes
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    // ALUControl codes
    localparam logic [ALUC_W-1:0] ALUC_ADD = 3'b000;
    localparam logic [ALUC_W-1:0] ALUC_SUB = 3'b001;
    localparam logic [ALUC_W-1:0] ALUC_AND = 3'b010;
    localparam logic [ALUC_W-1:0] ALUC_OR  = 3'b011;
    localparam logic [ALUC_W-1:0] ALUC_SLT = 3'b101;

    // resultSrc selects
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // ALUSrcA selects
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    // ALUSrcB selects
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // immSrc selects
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // ALU operation class: fixed add, fixed sub, or decoded from funct fields
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    // Per-state Moore control word. branch and mem_gate are qualifiers
    // resolved against zero/memReady at the output.
    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       instr_done;
        logic       branch;
        logic       mem_gate;
        logic [1:0] result_src;
        logic [1:0] src_a;
        logic [1:0] src_b;
        aluop_t     aluop;
    } ctrl_t;

    // Control word for a state; unlisted fields keep the FETCH selects and no strobes.
    function automatic ctrl_t moore_ctrl(input state_t s);
        ctrl_t c;
        c            = '0;
        c.result_src = RES_ALU;
        c.src_a      = SRCA_PC;
        c.src_b      = SRCB_FOUR;
        c.aluop      = ALUOP_ADD;
        case (s)
            S_FETCH: begin
                c.ir_write = 1'b1;
                c.pc_write = 1'b1;
                c.mem_gate = 1'b1;
            end
            S_DECODE: begin
                c.src_a = SRCA_OLDPC;
                c.src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                c.src_a = SRCA_RS1;
                c.src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                c.adr_src    = 1'b1;
                c.result_src = RES_ALUOUT;
                c.mem_gate   = 1'b1;
            end
            S_MEMWB: begin
                c.result_src = RES_MEM;
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr_src    = 1'b1;
                c.result_src = RES_ALUOUT;
                c.mem_write  = 1'b1;
                c.instr_done = 1'b1;
                c.mem_gate   = 1'b1;
            end
            S_EXECR: begin
                c.src_a = SRCA_RS1;
                c.src_b = SRCB_RS2;
                c.aluop = ALUOP_FUNCT;
            end
            S_EXECI: begin
                c.src_a = SRCA_RS1;
                c.src_b = SRCB_IMM;
                c.aluop = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                c.result_src = RES_ALUOUT;
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            S_JAL: begin
                c.src_a      = SRCA_OLDPC;
                c.src_b      = SRCB_FOUR;
                c.result_src = RES_ALUOUT;
                c.pc_write   = 1'b1;
            end
            S_BEQ: begin
                c.src_a      = SRCA_RS1;
                c.src_b      = SRCB_RS2;
                c.aluop      = ALUOP_SUB;
                c.result_src = RES_ALUOUT;
                c.branch     = 1'b1;
                c.instr_done = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multi_cycle_controller_alu_control_decoder.sv
// ALU control decoder: maps ALU op class and funct3/funct7/opcode[5] to ALUControl plus an illegal flag.
// Latency: purely combinational, zero cycles.
// Backpressure: none; illegal_o reflects funct3 alone so DECODE can check it before EXEC.
module multi_cycle_controller_alu_control_decoder
    import multi_cycle_controller_pkg::*;
(
    input  aluop_t            aluop_i,
    input  logic [2:0]        funct3_i,
    input  logic              funct7_i,
    input  logic              op5_i,
    output logic [ALUC_W-1:0] alu_control_o,
    output logic              illegal_o
);

    logic [ALUC_W-1:0] funct_code;

    // funct3 decode; sub only for R-type (opcode[5]=1) with funct7 set, so I-ALU ignores IR[30]
    always_comb begin
        funct_code = ALUC_ADD;
        illegal_o  = 1'b0;
        case (funct3_i)
            3'b000:  funct_code = (op5_i && funct7_i) ? ALUC_SUB : ALUC_ADD;
            3'b010:  funct_code = ALUC_SLT;
            3'b110:  funct_code = ALUC_OR;
            3'b111:  funct_code = ALUC_AND;
            default: illegal_o  = 1'b1;
        endcase
    end

    // Select between the fixed operations and the decoded one
    always_comb begin
        alu_control_o = ALUC_ADD;
        case (aluop_i)
            ALUOP_SUB:   alu_control_o = ALUC_SUB;
            ALUOP_FUNCT: alu_control_o = funct_code;
            default:     alu_control_o = ALUC_ADD;
        endcase
    end

endmodule

// File: rtl/multi_cycle_controller.sv
// Multi-cycle datapath controller: Moore FSM stepping one micro-op per clk (build option MULTI_CYCLE_MEM_READY_EN).
// Latency: lw 5, sw/R/I/jal 4, beq 3 cycles without stalls; one instrDone per retired instruction.
// Backpressure: with MULTI_CYCLE_MEM_READY_EN, FETCH/MEMREAD/MEMWRITE hold until memReady; otherwise never stalls.
module multi_cycle_controller
    import multi_cycle_controller_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic              funct7,
    input  logic              zero,
`ifdef MULTI_CYCLE_MEM_READY_EN
    input  logic              memReady,
`endif
    output logic              PCWrite,
    output logic              AdrSrc,
    output logic              memWrite,
    output logic              IRWrite,
    output logic [1:0]        resultSrc,
    output logic [1:0]        ALUSrcA,
    output logic [1:0]        ALUSrcB,
    output logic [1:0]        immSrc,
    output logic [ALUC_W-1:0] ALUControl,
    output logic              regWrite,
    output logic              instrDone,
    output logic              illegalInstr
);

    logic mem_ready;

`ifdef MULTI_CYCLE_MEM_READY_EN
    assign mem_ready = memReady;
`else
    assign mem_ready = 1'b1;
`endif

    state_t            state_q;
    state_t            state_d;
    ctrl_t             ctrl_q;
    logic              funct3_illegal;
    logic              opcode_known;
    logic              instr_illegal;
    logic              state_legal;
    logic              strobe_en;
    logic              mem_ok;

    multi_cycle_controller_alu_control_decoder u_alu_control_decoder (
        .aluop_i       (ctrl_q.aluop),
        .funct3_i      (funct3),
        .funct7_i      (funct7),
        .op5_i         (opcode[5]),
        .alu_control_o (ALUControl),
        .illegal_o     (funct3_illegal)
    );

    // Classify the instruction held in IR; only R/I-ALU carry a funct3 that can be unsupported
    always_comb begin
        opcode_known = 1'b0;
        case (opcode)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_IALU, OP_BEQ, OP_JAL: opcode_known = 1'b1;
            default: opcode_known = 1'b0;
        endcase
        instr_illegal = !opcode_known ||
                        (((opcode == OP_RTYPE) || (opcode == OP_IALU)) && funct3_illegal);
    end

    // Next-state sequencing; memory states wait on mem_ready
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (instr_illegal) begin
                    state_d = S_FETCH;
                end else begin
                    case (opcode)
                        OP_LOAD, OP_STORE: state_d = S_MEMADR;
                        OP_RTYPE:          state_d = S_EXECR;
                        OP_IALU:           state_d = S_EXECI;
                        OP_BEQ:            state_d = S_BEQ;
                        OP_JAL:            state_d = S_JAL;
                        default:           state_d = S_FETCH;
                    endcase
                end
            end
            S_MEMADR:   state_d = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_BEQ:      state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // State and its control word register together so outputs come straight from flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            ctrl_q  <= moore_ctrl(S_FETCH);
        end else begin
            state_q <= state_d;
            ctrl_q  <= moore_ctrl(state_d);
        end
    end

    // Strobes are killed during reset and in unused encodings; mem_gate strobes also wait on mem_ready
    always_comb begin
        state_legal  = (state_q <= S_BEQ);
        strobe_en    = !rst && state_legal;
        mem_ok       = !ctrl_q.mem_gate || mem_ready;
        PCWrite      = strobe_en && ((ctrl_q.pc_write && mem_ok) || (ctrl_q.branch && zero));
        IRWrite      = strobe_en && ctrl_q.ir_write && mem_ok;
        memWrite     = strobe_en && ctrl_q.mem_write;
        regWrite     = strobe_en && ctrl_q.reg_write;
        instrDone    = strobe_en && ctrl_q.instr_done && mem_ok;
        illegalInstr = !rst && (state_q == S_DECODE) && instr_illegal;
        AdrSrc       = ctrl_q.adr_src;
        resultSrc    = ctrl_q.result_src;
        ALUSrcA      = ctrl_q.src_a;
        ALUSrcB      = ctrl_q.src_b;
    end

    // Immediate format follows the opcode directly
    always_comb begin
        immSrc = IMM_I;
        case (opcode)
            OP_STORE: immSrc = IMM_S;
            OP_BEQ:   immSrc = IMM_B;
            OP_JAL:   immSrc = IMM_J;
            default:  immSrc = IMM_I;
        endcase
    end

endmodule

// File: tb/tb_multi_cycle_controller.sv
module tb_multi_cycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7;
    logic       zero;
`ifdef MULTI_CYCLE_MEM_READY_EN
    logic       memReady;
`endif
    logic       PCWrite, AdrSrc, memWrite, IRWrite, regWrite, instrDone, illegalInstr;
    logic [1:0] resultSrc, ALUSrcA, ALUSrcB, immSrc;
    logic [2:0] ALUControl;

    int checks   = 0;
    int failures = 0;

    // Output vector: PCWrite,AdrSrc,memWrite,IRWrite,resultSrc,ALUSrcA,ALUSrcB,regWrite,instrDone,illegalInstr
    localparam logic [12:0] E_RST   = 13'b0_0_0_0_10_00_10_0_0_0;
    localparam logic [12:0] E_FETCH = 13'b1_0_0_1_10_00_10_0_0_0;
    localparam logic [12:0] E_DEC   = 13'b0_0_0_0_00_01_01_0_0_0;
    localparam logic [12:0] E_DECIL = 13'b0_0_0_0_00_01_01_0_0_1;
    localparam logic [12:0] E_MADR  = 13'b0_0_0_0_00_10_01_0_0_0;
    localparam logic [12:0] E_MRD   = 13'b0_1_0_0_00_00_00_0_0_0;
    localparam logic [12:0] E_MWB   = 13'b0_0_0_0_01_00_00_1_1_0;
    localparam logic [12:0] E_MWR   = 13'b0_1_1_0_00_00_00_0_1_0;
    localparam logic [12:0] E_EXR   = 13'b0_0_0_0_00_10_00_0_0_0;
    localparam logic [12:0] E_EXI   = 13'b0_0_0_0_00_10_01_0_0_0;
    localparam logic [12:0] E_AWB   = 13'b0_0_0_0_00_00_00_1_1_0;
    localparam logic [12:0] E_JAL   = 13'b1_0_0_0_00_01_10_0_0_0;
    localparam logic [12:0] E_BEQT  = 13'b1_0_0_0_00_10_00_0_1_0;
    localparam logic [12:0] E_BEQN  = 13'b0_0_0_0_00_10_00_0_1_0;
`ifdef MULTI_CYCLE_MEM_READY_EN
    localparam logic [12:0] E_MWRW  = 13'b0_1_1_0_00_00_00_0_0_0;
`endif

    localparam logic [12:0] M_ALL = 13'b1_1_1_1_11_11_11_1_1_1;
    localparam logic [12:0] M_STB = 13'b1_0_1_1_00_00_00_1_1_1;
    localparam logic [12:0] M_ADR = 13'b0_1_0_0_00_00_00_0_0_0;
    localparam logic [12:0] M_RES = 13'b0_0_0_0_11_00_00_0_0_0;
    localparam logic [12:0] M_A   = 13'b0_0_0_0_00_11_00_0_0_0;
    localparam logic [12:0] M_B   = 13'b0_0_0_0_00_00_11_0_0_0;

    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] RT   = 7'b0110011;
    localparam logic [6:0] IA   = 7'b0010011;
    localparam logic [6:0] BEQ  = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] BAD  = 7'b1111111;

    multi_cycle_controller dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .funct3       (funct3),
        .funct7       (funct7),
        .zero         (zero),
`ifdef MULTI_CYCLE_MEM_READY_EN
        .memReady     (memReady),
`endif
        .PCWrite      (PCWrite),
        .AdrSrc       (AdrSrc),
        .memWrite     (memWrite),
        .IRWrite      (IRWrite),
        .resultSrc    (resultSrc),
        .ALUSrcA      (ALUSrcA),
        .ALUSrcB      (ALUSrcB),
        .immSrc       (immSrc),
        .ALUControl   (ALUControl),
        .regWrite     (regWrite),
        .instrDone    (instrDone),
        .illegalInstr (illegalInstr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [12:0] exp, input logic [12:0] mask);
        logic [12:0] obs;
        obs = {PCWrite, AdrSrc, memWrite, IRWrite, resultSrc, ALUSrcA, ALUSrcB,
               regWrite, instrDone, illegalInstr};
        checks++;
        assert ((obs & mask) === (exp & mask)) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b mask=%b", tag, obs, exp, mask);
        end
    endtask

    task automatic chk_v(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        rst    = 1'b1;
        opcode = LW;
        funct3 = 3'b010;
        funct7 = 1'b0;
        zero   = 1'b0;
`ifdef MULTI_CYCLE_MEM_READY_EN
        memReady = 1'b1;
`endif
        tick();
        chk("reset_hold", E_RST, M_ALL);
        tick();
        rst = 1'b0;
        #1;
        chk("first_fetch_after_reset", E_FETCH, M_ALL);

        // lw interrupted by reset in MEMREAD
        tick();  chk("lw_a_decode", E_DEC, M_STB | M_A | M_B);
        tick();  chk("lw_a_memadr", E_MADR, M_STB | M_A | M_B);
        tick();  chk("lw_a_memread", E_MRD, M_STB | M_ADR | M_RES);
        rst = 1'b1;
        #1;
        chk("reset_mid_memread", E_RST, M_ALL);
        tick();  chk("reset_mid_hold", E_RST, M_ALL);
        rst = 1'b0;
        #1;
        chk("fetch_after_abort", E_FETCH, M_ALL);

        // full lw: 5 cycles
        tick();  chk("lw_decode", E_DEC, M_STB | M_A | M_B);
        chk_v("lw_immsrc", {1'b0, immSrc}, 3'b000);
        tick();  chk("lw_memadr", E_MADR, M_STB | M_A | M_B);
        chk_v("lw_memadr_aluc", ALUControl, 3'b000);
        tick();  chk("lw_memread", E_MRD, M_STB | M_ADR | M_RES);
        tick();  chk("lw_memwb", E_MWB, M_STB | M_RES);
        opcode = SW;
        tick();  chk("sw_fetch", E_FETCH, M_ALL);

        // sw: 4 cycles
        tick();  chk("sw_decode", E_DEC, M_STB | M_A | M_B);
        chk_v("sw_immsrc", {1'b0, immSrc}, 3'b001);
`ifdef MULTI_CYCLE_MEM_READY_EN
        memReady = 1'b0;
        tick();  chk("sw_memadr", E_MADR, M_STB | M_A | M_B);
        tick();  chk("sw_wait1", E_MWRW, M_STB | M_ADR | M_RES);
        tick();  chk("sw_wait2", E_MWRW, M_STB | M_ADR | M_RES);
        tick();  chk("sw_wait3", E_MWRW, M_STB | M_ADR | M_RES);
        memReady = 1'b1;
        #1;
        chk("sw_memwrite_ready", E_MWR, M_STB | M_ADR | M_RES);
`else
        tick();  chk("sw_memadr", E_MADR, M_STB | M_A | M_B);
        tick();  chk("sw_memwrite", E_MWR, M_STB | M_ADR | M_RES);
`endif
        opcode = RT; funct3 = 3'b000; funct7 = 1'b0;
        tick();  chk("add_fetch", E_FETCH, M_ALL);

        // R add then sub
        tick();  chk("add_decode", E_DEC, M_STB | M_A | M_B);
        tick();  chk("add_execr", E_EXR, M_STB | M_A | M_B);
        chk_v("add_aluc", ALUControl, 3'b000);
        tick();  chk("add_aluwb", E_AWB, M_STB | M_RES);
        funct7 = 1'b1;
        tick();  tick();
        tick();  chk("sub_execr", E_EXR, M_STB | M_A | M_B);
        chk_v("sub_aluc", ALUControl, 3'b001);
        tick();  chk("sub_aluwb", E_AWB, M_STB | M_RES);
        funct3 = 3'b010; funct7 = 1'b0;
        tick();  tick();
        tick();  chk_v("slt_aluc", ALUControl, 3'b101);
        tick();
        funct3 = 3'b110;
        tick();  tick();
        tick();  chk_v("or_aluc", ALUControl, 3'b011);
        tick();

        // addi with IR[30]=1 must still add
        opcode = IA; funct3 = 3'b000; funct7 = 1'b1;
        tick();  tick();
        tick();  chk("addi_execi", E_EXI, M_STB | M_A | M_B);
        chk_v("addi_f7_aluc", ALUControl, 3'b000);
        tick();  chk("addi_aluwb", E_AWB, M_STB | M_RES);
        funct3 = 3'b111; funct7 = 1'b0;
        tick();  tick();
        tick();  chk_v("andi_aluc", ALUControl, 3'b010);
        tick();

        // beq taken then not taken: 3 cycles
        opcode = BEQ; funct3 = 3'b000; zero = 1'b1;
        tick();  chk("beq_fetch", E_FETCH, M_ALL);
        tick();  chk_v("beq_immsrc", {1'b0, immSrc}, 3'b010);
        tick();  chk("beq_taken", E_BEQT, M_STB | M_A | M_B | M_RES);
        chk_v("beq_aluc", ALUControl, 3'b001);
        zero = 1'b0;
        tick();  chk("beq2_fetch", E_FETCH, M_ALL);
        tick();
        tick();  chk("beq_not_taken", E_BEQN, M_STB | M_A | M_B | M_RES);

        // jal: 4 cycles
        opcode = JAL;
        tick();  chk("jal_fetch", E_FETCH, M_ALL);
        tick();  chk_v("jal_immsrc", {1'b0, immSrc}, 3'b011);
        tick();  chk("jal_state", E_JAL, M_STB | M_A | M_B | M_RES);
        chk_v("jal_aluc", ALUControl, 3'b000);
        tick();  chk("jal_aluwb", E_AWB, M_STB | M_RES);

        // illegal opcode and illegal R funct3
        opcode = BAD;
        tick();  chk("bad_fetch", E_FETCH, M_ALL);
        tick();  chk("bad_decode", E_DECIL, M_STB | M_A | M_B);
        tick();  chk("bad_refetch", E_FETCH, M_ALL);
        opcode = RT; funct3 = 3'b001;
        tick();  chk("badf3_decode", E_DECIL, M_STB | M_A | M_B);
        tick();  chk("badf3_refetch", E_FETCH, M_ALL);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
